// File: rtl/branch_target_unit.sv
// Branch/jump target computation with a one-entry valid/ready output stage.
// Also keeps a saturating count of taken results handed downstream.
module branch_target_unit #(
    parameter int N_BITS_DW    = 32,
    parameter int N_BITS_W     = 16,
    parameter int N_BITS_JADDR = 26,
    parameter int N_BITS_CNT   = 16
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic                    o_valid,
    input  logic                    i_ready,
    input  logic                    i_flush,
    input  logic [1:0]              i_mode,
    input  logic [1:0]              i_cond,
    input  logic [N_BITS_DW-1:0]    i_pc,
    input  logic [N_BITS_W-1:0]     i_imm,
    input  logic [N_BITS_JADDR-1:0] i_jaddr,
    input  logic [N_BITS_DW-1:0]    i_reg_a,
    input  logic [N_BITS_DW-1:0]    i_reg_b,
    output logic [N_BITS_DW-1:0]    o_target,
    output logic [N_BITS_DW-1:0]    o_sign_extension,
    output logic [N_BITS_DW-1:0]    o_link,
    output logic                    o_taken,
    output logic                    o_illegal,
    output logic                    o_misaligned,
    output logic [N_BITS_CNT-1:0]   o_taken_count
);

    typedef enum logic {EMPTY, FULL} state_t;

    localparam logic [1:0] MODE_BRANCH = 2'b00;
    localparam logic [1:0] MODE_JUMP   = 2'b01;
    localparam logic [1:0] MODE_JREG   = 2'b10;

    state_t                 state, state_next;
    logic                   load, out_hs;
    logic [N_BITS_DW-1:0]   sign_ext, jump_tgt, target_c, link_c;
    logic                   cond_c, illegal_c, misaligned_c, taken_c;

    generate
        if (N_BITS_DW > N_BITS_W) begin : g_sext
            assign sign_ext = {{(N_BITS_DW-N_BITS_W){i_imm[N_BITS_W-1]}}, i_imm};
        end else begin : g_strunc
            assign sign_ext = i_imm[N_BITS_DW-1:0];
        end
        if (N_BITS_DW > N_BITS_JADDR + 2) begin : g_jump
            assign jump_tgt = {i_pc[N_BITS_DW-1:N_BITS_JADDR+2], i_jaddr, 2'b00};
        end else begin : g_jtrunc
            assign jump_tgt = N_BITS_DW'({i_jaddr, 2'b00});
        end
    endgenerate

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        target_c     = i_pc;
        illegal_c    = 1'b0;
        misaligned_c = 1'b0;
        link_c       = i_pc + N_BITS_DW'(4);
        case (i_mode)
            MODE_BRANCH: target_c = i_pc + (sign_ext << 2);
            MODE_JUMP:   target_c = jump_tgt;
            MODE_JREG: begin
                target_c     = i_reg_a;
                misaligned_c = (i_reg_a[1:0] != 2'b00);
            end
            default:     illegal_c = 1'b1;
        endcase
        case (i_cond)
            2'b00:   cond_c = 1'b1;
            2'b01:   cond_c = (i_reg_a == i_reg_b);
            2'b10:   cond_c = (i_reg_a != i_reg_b);
            default: cond_c = 1'b0;
        endcase
        taken_c = cond_c & ~illegal_c & ~misaligned_c;
    end

    always_comb begin
        state_next = state;
        o_valid    = (state == FULL);
        o_ready    = (state == EMPTY) | i_ready;
        if (i_flush) begin
            state_next = EMPTY;
        end else if (state == EMPTY) begin
            if (i_valid) state_next = FULL;
        end else if (i_ready) begin
            state_next = i_valid ? FULL : EMPTY;
        end
    end

    assign load   = o_ready & i_valid & ~i_flush;
    assign out_hs = o_valid & i_ready & ~i_flush;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state            <= EMPTY;
            o_target         <= '0;
            o_sign_extension <= '0;
            o_link           <= '0;
            o_taken          <= 1'b0;
            o_illegal        <= 1'b0;
            o_misaligned     <= 1'b0;
            o_taken_count    <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                o_target         <= target_c;
                o_sign_extension <= sign_ext;
                o_link           <= link_c;
                o_taken          <= taken_c;
                o_illegal        <= illegal_c;
                o_misaligned     <= misaligned_c;
            end
            // Counts the result leaving this cycle, before any new load replaces it.
            if (out_hs && o_taken && (o_taken_count != '1))
                o_taken_count <= o_taken_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_target_unit.sv
// Directed-vector bench for branch_target_unit; a second instance with a
// 2-bit counter exercises counter saturation on the same stimulus.
module tb_branch_target_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, ready, flush;
    logic [1:0]  mode, cond;
    logic [31:0] pc, reg_a, reg_b;
    logic [15:0] imm;
    logic [25:0] jaddr;

    logic        o_ready, o_valid, o_taken, o_illegal, o_misaligned;
    logic [31:0] o_target, o_sext, o_link;
    logic [15:0] o_cnt;
    logic        c2_ready, c2_valid, c2_taken, c2_illegal, c2_misaligned;
    logic [31:0] c2_target, c2_sext, c2_link;
    logic [1:0]  c2_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_target_unit dut (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .o_ready(o_ready),
        .o_valid(o_valid), .i_ready(ready), .i_flush(flush), .i_mode(mode),
        .i_cond(cond), .i_pc(pc), .i_imm(imm), .i_jaddr(jaddr),
        .i_reg_a(reg_a), .i_reg_b(reg_b), .o_target(o_target),
        .o_sign_extension(o_sext), .o_link(o_link), .o_taken(o_taken),
        .o_illegal(o_illegal), .o_misaligned(o_misaligned), .o_taken_count(o_cnt)
    );

    branch_target_unit #(.N_BITS_CNT(2)) dut_c2 (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .o_ready(c2_ready),
        .o_valid(c2_valid), .i_ready(ready), .i_flush(flush), .i_mode(mode),
        .i_cond(cond), .i_pc(pc), .i_imm(imm), .i_jaddr(jaddr),
        .i_reg_a(reg_a), .i_reg_b(reg_b), .o_target(c2_target),
        .o_sign_extension(c2_sext), .o_link(c2_link), .o_taken(c2_taken),
        .o_illegal(c2_illegal), .o_misaligned(c2_misaligned), .o_taken_count(c2_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic r, input logic f,
                         input logic [1:0] m, input logic [1:0] c,
                         input logic [31:0] p, input logic [15:0] im,
                         input logic [25:0] ja, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        valid = v; ready = r; flush = f; mode = m; cond = c;
        pc = p; imm = im; jaddr = ja; reg_a = a; reg_b = b;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_res(input string tag, input logic v,
                              input logic [31:0] tgt, input logic [31:0] sx,
                              input logic [31:0] lk, input logic tk,
                              input logic il, input logic mis, input int cnt);
        int c2;
        c2 = (cnt > 3) ? 3 : cnt;
        check({tag, ".valid"}, 64'(o_valid), 64'(v));
        check({tag, ".target"}, 64'(o_target), 64'(tgt));
        check({tag, ".sext"}, 64'(o_sext), 64'(sx));
        check({tag, ".link"}, 64'(o_link), 64'(lk));
        check({tag, ".taken"}, 64'(o_taken), 64'(tk));
        check({tag, ".illegal"}, 64'(o_illegal), 64'(il));
        check({tag, ".misaligned"}, 64'(o_misaligned), 64'(mis));
        check({tag, ".count"}, 64'(o_cnt), 64'(cnt));
        check({tag, ".count_c2"}, 64'(c2_cnt), 64'(c2));
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; ready = 1'b1; flush = 1'b0;
        mode = 2'b00; cond = 2'b00; pc = '0; imm = '0; jaddr = '0;
        reg_a = '0; reg_b = '0;
        drive(1, 1, 0, 2'b00, 2'b00, 32'h100, 16'hFFFE, 0, 0, 0);
        drive(1, 1, 1, 2'b00, 2'b00, 32'h100, 16'hFFFE, 0, 0, 0);
        expect_res("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0; valid = 1'b0;
        #1;
        check("ready_after_reset", 64'(o_ready), 64'd1);

        // mode, cond: 00 BRANCH / 01 JUMP / 10 JREG / 11 reserved
        drive(1, 1, 0, 2'b00, 2'b00, 32'h0000_0100, 16'hFFFE, 0, 0, 0);
        expect_res("branch_back", 1, 32'h0000_00F8, 32'hFFFF_FFFE, 32'h0000_0104, 1, 0, 0, 0);
        drive(1, 1, 0, 2'b01, 2'b00, 32'hA000_0010, 16'h0000, 26'h40, 0, 0);
        expect_res("jump", 1, 32'hA000_0100, 0, 32'hA000_0014, 1, 0, 0, 1);
        drive(1, 1, 0, 2'b00, 2'b01, 32'h0000_0200, 16'h0004, 0, 5, 6);
        expect_res("beq_ne", 1, 32'h0000_0210, 4, 32'h0000_0204, 0, 0, 0, 2);
        drive(1, 1, 0, 2'b00, 2'b10, 32'h0000_0200, 16'h0004, 0, 5, 6);
        expect_res("bne_ne", 1, 32'h0000_0210, 4, 32'h0000_0204, 1, 0, 0, 2);
        drive(1, 1, 0, 2'b10, 2'b00, 32'h0000_0400, 16'h0000, 0, 32'h1003, 0);
        expect_res("jreg_mis", 1, 32'h0000_1003, 0, 32'h0000_0404, 0, 0, 1, 3);
        drive(1, 1, 0, 2'b11, 2'b00, 32'h0000_0300, 16'h8000, 0, 0, 0);
        expect_res("reserved", 1, 32'h0000_0300, 32'hFFFF_8000, 32'h0000_0304, 0, 1, 0, 3);
        drive(1, 1, 0, 2'b10, 2'b00, 32'h0000_0500, 16'h0000, 0, 32'h2000, 0);
        expect_res("jreg_ok", 1, 32'h0000_2000, 0, 32'h0000_0504, 1, 0, 0, 3);
        drive(1, 1, 0, 2'b00, 2'b00, 32'hFFFF_FFFC, 16'h0001, 0, 0, 0);
        expect_res("branch_wrap", 1, 32'h0000_0000, 1, 32'h0000_0000, 1, 0, 0, 4);

        // Back-pressure: held result must not move while operands change.
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 2'(i), 2'b00, 32'h7770 + 32'(i), 16'h1234, 26'h3, 32'h55, 32'h55);
            expect_res("stall", 1, 32'h0000_0000, 1, 32'h0000_0000, 1, 0, 0, 4);
            check("stall.ready", 64'(o_ready), 64'd0);
        end
        drive(1, 1, 0, 2'b00, 2'b00, 32'h0000_1000, 16'h0010, 0, 0, 0);
        expect_res("after_stall", 1, 32'h0000_1040, 32'h10, 32'h0000_1004, 1, 0, 0, 5);

        // Flush in FULL with a request present: drop both, count unchanged.
        drive(1, 1, 1, 2'b00, 2'b00, 32'h0000_9000, 16'h0000, 0, 0, 0);
        expect_res("flush_full", 0, 32'h0000_1040, 32'h10, 32'h0000_1004, 1, 0, 0, 5);
        check("flush_full.ready", 64'(o_ready), 64'd1);
        drive(0, 1, 0, 2'b00, 2'b00, 32'h0000_9000, 16'h0000, 0, 0, 0);
        check("idle.valid", 64'(o_valid), 64'd0);
        drive(1, 1, 1, 2'b01, 2'b00, 32'h0000_9000, 16'h0000, 26'h7, 0, 0);
        expect_res("flush_empty", 0, 32'h0000_1040, 32'h10, 32'h0000_1004, 1, 0, 0, 5);

        drive(1, 1, 0, 2'b01, 2'b00, 32'h0000_0010, 16'h0000, 26'h1, 0, 0);
        expect_res("jump_low", 1, 32'h0000_0004, 0, 32'h0000_0014, 1, 0, 0, 5);
        drive(0, 1, 0, 2'b00, 2'b00, 32'h0, 16'h0, 0, 0, 0);
        expect_res("drain", 0, 32'h0000_0004, 0, 32'h0000_0014, 1, 0, 0, 6);

        // Reset asserted while FULL and stalled loses the held result.
        drive(1, 1, 0, 2'b00, 2'b00, 32'h0000_0100, 16'hFFFE, 0, 0, 0);
        expect_res("reload", 1, 32'h0000_00F8, 32'hFFFF_FFFE, 32'h0000_0104, 1, 0, 0, 6);
        @(negedge clk);
        rst = 1'b1;
        drive(1, 0, 0, 2'b00, 2'b00, 32'h0000_0100, 16'hFFFE, 0, 0, 0);
        expect_res("reset_full", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0; valid = 1'b0;
        #1;
        check("ready_after_reset2", 64'(o_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_target_unit.md
BRANCH_TARGET_UNIT -- requirements
Module: branch_target_unit

Interface
REQ-001 The block SHALL have parameter N_BITS_DW, default 32, for the data/PC width.
REQ-002 The block SHALL have parameter N_BITS_W, default 16, for the immediate width.
REQ-003 The block SHALL have parameter N_BITS_JADDR, default 26, for the J-type address field width.
REQ-004 The block SHALL have parameter N_BITS_CNT, default 16, for the taken-counter width.
REQ-005 The block SHALL have port i_clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port i_reset, input, width 1: reset, synchronous and active-high.
REQ-007 The block SHALL have these handshake ports: i_valid (in, 1, request present); o_ready (out, 1, request accepted this cycle); o_valid (out, 1, result present); i_ready (in, 1, downstream accepts result); i_flush (in, 1, discard held and incoming request).
REQ-008 The block SHALL have these control inputs: i_mode (2), 00 BRANCH, 01 JUMP, 10 JREG, 11 reserved; i_cond (2), 00 always, 01 equal, 10 not-equal, 11 never.
REQ-009 The block SHALL have these operand inputs: i_pc (N_BITS_DW, already-incremented PC); i_imm (N_BITS_W); i_jaddr (N_BITS_JADDR); i_reg_a and i_reg_b (N_BITS_DW).
REQ-010 The block SHALL have these result outputs, all N_BITS_DW: o_target (jump address); o_sign_extension (extended immediate); o_link (i_pc + 4).
REQ-011 The block SHALL have these status outputs: o_taken (1); o_illegal (1); o_misaligned (1); o_taken_count (N_BITS_CNT).

Function
REQ-012 sign_ext SHALL be i_imm with bit N_BITS_W-1 replicated to N_BITS_DW bits, for any parameter values.
REQ-013 BRANCH target SHALL be i_pc + (sign_ext << 2), computed modulo 2^N_BITS_DW with wrap-around and no overflow flag.
REQ-014 JUMP target SHALL be {i_pc[DW-1 : JADDR+2], i_jaddr, 2'b00}.
REQ-015 JREG target SHALL be i_reg_a, unmodified.
REQ-016 Reserved mode SHALL give target = i_pc, taken = 0, illegal = 1.
REQ-017 Condition SHALL be i_reg_a == i_reg_b for code 01, inequality for 10, constant 1 for 00 and constant 0 for 11; taken = condition AND NOT illegal AND NOT misaligned.
REQ-018 misaligned SHALL be 1 when target[1:0] != 0, evaluated in JREG mode only and 0 in all other modes.
REQ-019 FSM SHALL have two states, EMPTY and FULL.
REQ-020 In EMPTY: o_ready = 1 and o_valid = 0; i_valid & ~i_flush SHALL register the results and go to FULL.
REQ-021 In FULL: o_valid = 1 and o_ready = i_ready; i_ready & i_valid & ~i_flush SHALL load the new request and stay FULL; i_ready & ~i_valid SHALL go to EMPTY; ~i_ready SHALL hold all outputs stable.
REQ-022 Latency SHALL be 1 cycle from accepted request to o_valid, with full throughput (one result per cycle) while i_ready = 1.
REQ-023 i_flush SHALL take priority over all handshakes: next state EMPTY, request in the same cycle dropped, counter not incremented.
REQ-024 Registered outputs SHALL change only when a new request loads.
REQ-025 o_taken_count SHALL increment by 1 on each output handshake (o_valid & i_ready & ~i_flush) with o_taken = 1, and SHALL saturate at 2^N_BITS_CNT-1 with no wrap.

Reset
REQ-026 On i_reset = 1 at a clock edge: state EMPTY; o_valid = 0; o_target, o_sign_extension, o_link = 0; o_taken, o_illegal, o_misaligned = 0; o_taken_count = 0.
REQ-027 i_reset SHALL dominate i_flush and all handshakes, including when asserted in FULL, and the held result SHALL be lost.
REQ-028 o_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-029 BRANCH, cond 00, i_pc = 0x00000100, i_imm = 0xFFFE -> one cycle later: o_valid = 1, o_target = 0x000000F8, o_sign_extension = 0xFFFFFFFE, o_link = 0x00000104, o_taken = 1.
REQ-030 JUMP, i_pc = 0xA0000010, i_jaddr = 0x0000040 -> o_target = 0xA0000100, o_taken = 1; BRANCH cond 01 with reg_a = 5, reg_b = 6 -> o_taken = 0.
REQ-031 JREG, i_reg_a = 0x00001003 -> o_misaligned = 1, o_taken = 0; mode 11 -> o_illegal = 1, o_target = i_pc.
REQ-032 Back-pressure: result in FULL, i_ready = 0 for 3 cycles while operands change -> outputs unchanged and o_ready = 0; i_ready = 1 -> next request loads on that edge.
REQ-033 i_flush in FULL with i_valid = 1 -> EMPTY next cycle, o_valid = 0, o_taken_count unchanged; i_reset in FULL -> all outputs 0.
REQ-034 N_BITS_CNT = 2 with 5 taken handshakes -> o_taken_count = 3 (saturated); BRANCH i_pc = 0xFFFFFFFC, i_imm = 0x0001 -> o_target = 0x00000000.
